ndp_job_scheduler: RTL and testbench
====================================

# ndp_job_scheduler

Round-robin job scheduler that shares one NDP core among several host requesters. It grants the core to one requester at a time and pulses the core's synchronous reset. It then issues the load-start flag and streams the requester's 32-bit load words into the core one per cycle. Finally it waits for calc_done and reports completion or error back to the granted requester. It sits between the host-side request ports and the NDP core's data_in_flag/data_in/calc_done_flag ports; the core's result bus bypasses this block.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- LOAD_WORDS, 651, words per job load (matches core load sequence for SYS_HEIGHT=1, SYS_WIDTH=64)
- RST_CYCLES, 2, cycles core_reset is held before each job (>=1)
- TIMEOUT_CYCLES, 4096, max COMPUTE cycles before error

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester job request, level; held until req_done/req_err
- req_valid  in  NUM_REQ  per-requester load word valid
- req_data  in  32*NUM_REQ  per-requester load word, requester i at bits [32i+31:32i]
- req_ready  out  NUM_REQ  word accepted this cycle (granted requester, STREAM only)
- req_done  out  NUM_REQ  one-cycle job-complete pulse
- req_err  out  NUM_REQ  one-cycle job-abort pulse
- core_reset  out  1  synchronous reset to NDP core
- core_data_in_flag  out  1  load-start pulse to core
- core_data_in  out  32  load word to core
- core_calc_done  in  1  core calc_done_flag
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(NUM_REQ)  index of current/last grant

## Operation
- States: IDLE, CORE_RST, START, STREAM, COMPUTE, DONE, ERR.
- IDLE:
  - core_reset=1.
  - If any req bit is set, grant the first set bit searching from rr pointer upward with wrap; latch grant_id; reset counter; go to CORE_RST.
- CORE_RST: core_reset=1 for RST_CYCLES cycles, then START.
- START: core_reset=0; core_data_in_flag=1 for exactly one cycle; go to STREAM.
- STREAM:
  - req_ready[g]=1, all other ready bits 0.
  - Each cycle with req_valid[g]=1: core_data_in <= req_data[g], word counter +1.
  - After word LOAD_WORDS is accepted, go to COMPUTE.
  - req_valid[g]=0 in any STREAM cycle -> ERR (the core has no backpressure).
- COMPUTE:
  - Cycle counter runs from 0.
  - core_calc_done=1 -> DONE.
  - Counter reaches TIMEOUT_CYCLES -> ERR.
- DONE: req_done[g]=1 for one cycle; rr pointer <= (g+1) mod NUM_REQ; go to IDLE.
- ERR: req_err[g]=1 for one cycle; rr pointer <= (g+1) mod NUM_REQ; go to IDLE. The core is reset again in IDLE.
- req[g] deasserted while in CORE_RST/START/STREAM/COMPUTE -> ERR (abort).
- Requests from other requesters are ignored until return to IDLE; no preemption.
- Counters are sized clog2(max(LOAD_WORDS, TIMEOUT_CYCLES, RST_CYCLES)+1) and never wrap.
- core_calc_done in any state other than COMPUTE is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - state=IDLE, rr pointer=0, grant_id=0.
  - core_reset=1; core_data_in_flag=0; core_data_in=0.
  - req_ready=0, req_done=0, req_err=0, busy=0.
- Reset asserted mid-job: immediate return to reset values. No done/err pulse is issued for the interrupted job.
- req seen in IDLE at edge E: CORE_RST occupies E+1..E+RST_CYCLES; START is cycle E+RST_CYCLES+1.
- core_data_in_flag high in cycle S. Words appear on core_data_in in cycles S+1..S+LOAD_WORDS, one new word per cycle, in acceptance order.
- req_ready is high in STREAM cycles only. A word is accepted on the edge where ready&valid.
- req_done/req_err rise on the edge following the triggering COMPUTE/STREAM cycle.
- The next grant can be issued at the earliest on the cycle after DONE/ERR (one IDLE cycle minimum between jobs).
- Simultaneous core_calc_done and timeout in the same cycle -> DONE wins.
- Simultaneous req drop and valid drop in STREAM -> single ERR pulse.

## Test plan
- Single job: req[1]=1, valid held, LOAD_WORDS=651, RST_CYCLES=2. Expect:
  - core_reset high for 2 cycles, then core_data_in_flag pulse.
  - 651 words on core_data_in in the same order.
  - calc_done after 50 cycles -> one req_done[1] pulse; busy falls; grant_id=1.
- Round-robin: req=4'b1011 held continuously with valid always 1 and calc_done after 10 cycles. Expect grant order 0,1,3,0,1,3 with exactly one req_done per job.
- Stream stall: req_valid[2] dropped at word 100. Expect:
  - req_err[2] pulse, no req_done.
  - core_reset reasserted in the following IDLE.
  - Only 99 words forwarded.
- Timeout: TIMEOUT_CYCLES=64, calc_done never asserted. Expect req_err pulse exactly 64 cycles after COMPUTE entry; rr pointer advances.
- Simultaneous: calc_done asserted on the same cycle the timeout counter expires. Expect req_done, no req_err.
- Async reset mid-STREAM at word 300. Expect:
  - All outputs return to reset values without waiting for a clk edge; no done/err pulse.
  - With req still held, a new job starts from CORE_RST with rr pointer=0.

Source files
------------

// File: rtl/ndp_job_scheduler_if.sv
// Host request ports and NDP core load ports shared by the job scheduler.
// Handshake: a load word moves on the rising clk edge where req_ready[i] && req_valid[i].
interface ndp_job_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_valid;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_done;
  logic [NUM_REQ-1:0]    req_err;
  logic                  core_reset;
  logic                  core_data_in_flag;
  logic [31:0]           core_data_in;
  logic                  core_calc_done;

  modport slave (
    input  req, req_valid, req_data, core_calc_done,
    output req_ready, req_done, req_err, core_reset, core_data_in_flag, core_data_in
  );

  modport master (
    output req, req_valid, req_data, core_calc_done,
    input  req_ready, req_done, req_err, core_reset, core_data_in_flag, core_data_in
  );
endinterface

// File: rtl/ndp_job_scheduler.sv
// Round-robin scheduler granting one NDP core to one host requester at a time:
// reset core, pulse load-start, stream LOAD_WORDS words, wait for calc_done.
module ndp_job_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int LOAD_WORDS     = 651,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  ndp_job_scheduler_if.slave         bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [2:0]                 state_dbg
);
  localparam int GW    = $clog2(NUM_REQ);
  localparam int MAX_A = (LOAD_WORDS > TIMEOUT_CYCLES) ? LOAD_WORDS : TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CORE_RST, S_START, S_STREAM, S_COMPUTE, S_DONE, S_ERR
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [GW-1:0]      rr, rr_n, grant_n, pick;
  logic               found, req_g, valid_g, accept;
  logic [31:0]        data_g;
  logic [NUM_REQ-1:0] grant_oh;

  assign state_dbg = state;
  assign req_g     = bus.req[grant_id];
  assign valid_g   = bus.req_valid[grant_id];
  assign data_g    = bus.req_data[32*int'(grant_id) +: 32];
  assign grant_oh  = NUM_REQ'(1) << grant_n;

  // First requesting index at or above rr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req[(int'(rr) + i) % NUM_REQ]) begin
        found = 1'b1;
        pick  = GW'((int'(rr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rr_n    = rr;
    grant_n = grant_id;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_n = pick;
          cnt_n   = '0;
          state_n = S_CORE_RST;
        end
      end
      S_CORE_RST: begin
        if (!req_g) state_n = S_ERR;
        else if (cnt == CW'(RST_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = S_START;
        end else cnt_n = cnt + 1'b1;
      end
      S_START: begin
        cnt_n   = '0;
        state_n = req_g ? S_STREAM : S_ERR;
      end
      S_STREAM: begin
        // The core cannot stall, so a missing word aborts the job.
        accept = valid_g;
        if (!req_g || !valid_g) state_n = S_ERR;
        else if (cnt == CW'(LOAD_WORDS - 1)) begin
          cnt_n   = '0;
          state_n = S_COMPUTE;
        end else cnt_n = cnt + 1'b1;
      end
      S_COMPUTE: begin
        if (!req_g) state_n = S_ERR;
        else if (bus.core_calc_done) state_n = S_DONE;
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) state_n = S_ERR;
        else cnt_n = cnt + 1'b1;
      end
      S_DONE, S_ERR: begin
        rr_n    = (grant_id == GW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= S_IDLE;
      cnt                   <= '0;
      rr                    <= '0;
      grant_id              <= '0;
      busy                  <= 1'b0;
      bus.core_reset        <= 1'b1;
      bus.core_data_in_flag <= 1'b0;
      bus.core_data_in      <= '0;
      bus.req_ready         <= '0;
      bus.req_done          <= '0;
      bus.req_err           <= '0;
    end else begin
      state                 <= state_n;
      cnt                   <= cnt_n;
      rr                    <= rr_n;
      grant_id              <= grant_n;
      busy                  <= (state_n != S_IDLE);
      bus.core_reset        <= (state_n == S_IDLE) || (state_n == S_CORE_RST);
      bus.core_data_in_flag <= (state_n == S_START);
      if (accept) bus.core_data_in <= data_g;
      bus.req_ready         <= (state_n == S_STREAM) ? grant_oh : '0;
      bus.req_done          <= (state_n == S_DONE)   ? grant_oh : '0;
      bus.req_err           <= (state_n == S_ERR)    ? grant_oh : '0;
    end
  end
endmodule

// File: tb/tb_ndp_job_scheduler.sv
// Directed bench for ndp_job_scheduler: job-level timeline model checked every cycle,
// plus literal expectations for grant order, word counts, timeout and reset behaviour.
module tb_ndp_job_scheduler;
  localparam int N  = 4;
  localparam int L  = 651;
  localparam int R  = 2;
  localparam int TO = 64;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;
  logic [2:0] state_dbg;

  ndp_job_scheduler_if #(.NUM_REQ(N)) bus ();

  ndp_job_scheduler #(
    .NUM_REQ(N), .LOAD_WORDS(L), .RST_CYCLES(R), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .grant_id(grant_id), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- job-level model ----------------
  // t counts cycles since the grant edge: 1..R core reset, R+1 load-start,
  // then streaming until L words are in, then compute. endk: 1 done, 2 err pulse cycle.
  typedef struct {
    bit          active;
    int          endk;
    int          rr;
    int          g;
    int          t;
    int          words;
    int          ccnt;
    logic [31:0] last;
    bit          newd;
  } model_t;

  model_t      m = '{default:0};
  logic [31:0] exp_q[$];

  function automatic bit streaming(model_t x);
    return x.active && x.endk == 0 && x.t > R + 1 && x.words < L;
  endfunction

  function automatic model_t step(model_t x, logic [N-1:0] rq, logic [N-1:0] vl,
                                  logic [32*N-1:0] dat, logic cd);
    model_t n;
    int     k, fin;
    bit     in_stream, in_comp;
    n = x;
    n.newd = 0;
    if (x.endk != 0) begin
      n.endk   = 0;
      n.active = 0;
    end else if (!x.active) begin
      for (int i = 0; i < N; i++) begin
        k = (x.rr + i) % N;
        if (!n.active && rq[k] === 1'b1) begin
          n.active = 1; n.g = k; n.t = 1; n.words = 0; n.ccnt = 0;
        end
      end
    end else begin
      fin       = 0;
      in_stream = streaming(x);
      in_comp   = x.t > R + 1 && x.words >= L;
      if (in_stream && vl[x.g]) begin
        n.last  = dat[32*x.g +: 32];
        n.newd  = 1;
        n.words = x.words + 1;
      end
      if (!rq[x.g]) fin = 2;
      else if (in_stream && !vl[x.g]) fin = 2;
      else if (in_comp) begin
        if (cd) fin = 1;
        else if (x.ccnt == TO - 1) fin = 2;
        else n.ccnt = x.ccnt + 1;
      end
      n.t = x.t + 1;
      if (fin != 0) begin
        n.endk = fin;
        n.rr   = (x.g + 1) % N;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '{default:0};
      exp_q.delete();
    end else begin
      if (streaming(m) && bus.req_valid[m.g]) exp_q.push_back(bus.req_data[32*m.g +: 32]);
      m <= step(m, bus.req, bus.req_valid, bus.req_data, bus.core_calc_done);
    end
  end

  function automatic logic [31:0] onehot_if(bit c, int g);
    return c ? (32'd1 << g) : 32'd0;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("core_reset", bus.core_reset, !m.active || (m.endk == 0 && m.t <= R));
    chk("core_data_in_flag", bus.core_data_in_flag, m.active && m.endk == 0 && m.t == R + 1);
    chk("req_ready", bus.req_ready, onehot_if(streaming(m), m.g));
    chk("req_done", bus.req_done, onehot_if(m.endk == 1, m.g));
    chk("req_err", bus.req_err, onehot_if(m.endk == 2, m.g));
    chk("busy", busy, m.active);
    chk("grant_id", grant_id, m.g);
    if (m.newd) begin
      if (exp_q.size() > 0) chk("core_data_in", bus.core_data_in, exp_q.pop_front());
      else chk("scoreboard_word_available", 0, 1);
    end else begin
      chk("core_data_in_hold", bus.core_data_in, m.last);
    end
  end

  // ---------------- event monitors ----------------
  int done_cnt[N], err_cnt[N], acc_cnt[N];
  int flag_cnt, rstbusy_cnt, job_words, comp_cycles;
  int grant_q[$];
  int calc_delay = -1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) acc_cnt[i] <= 0;
      job_words   <= 0;
      comp_cycles <= -1;
    end else begin
      for (int i = 0; i < N; i++)
        if (bus.req_ready[i] && bus.req_valid[i]) acc_cnt[i] <= acc_cnt[i] + 1;
      if (bus.core_data_in_flag) begin
        job_words   <= 0;
        comp_cycles <= -1;
      end else if (|(bus.req_ready & bus.req_valid)) begin
        job_words <= job_words + 1;
        if (job_words == L - 1) comp_cycles <= 0;
      end else if (job_words == L) begin
        comp_cycles <= comp_cycles + 1;
      end
    end
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        done_cnt[i] <= 0;
        err_cnt[i]  <= 0;
      end
      flag_cnt    <= 0;
      rstbusy_cnt <= 0;
      grant_q.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        done_cnt[i] <= done_cnt[i] + int'(bus.req_done[i]);
        err_cnt[i]  <= err_cnt[i] + int'(bus.req_err[i]);
      end
      if (bus.core_data_in_flag) begin
        flag_cnt <= flag_cnt + 1;
        grant_q.push_back(int'(grant_id));
      end
      if (busy && bus.core_reset) rstbusy_cnt <= rstbusy_cnt + 1;
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    int tick;
    tick = 0;
    bus.req_data = '0;
    forever begin
      @(negedge clk);
      tick++;
      for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = {i[7:0], 8'hD0, tick[15:0]};
    end
  end

  // Core model: raise calc_done for one cycle at compute cycle calc_delay.
  initial begin
    bus.core_calc_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.core_calc_done = (calc_delay >= 0 && job_words == L && comp_cycles == calc_delay);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_end(input int i, input int budget);
    int base, c;
    base = done_cnt[i] + err_cnt[i];
    c = 0;
    while (done_cnt[i] + err_cnt[i] == base && c < budget) begin
      @(negedge clk); #1; c++;
    end
    chk("job_end_seen", (done_cnt[i] + err_cnt[i]) != base, 1);
  endtask

  task automatic wait_acc(input int i, input int n, input int budget);
    int c;
    c = 0;
    while (acc_cnt[i] < n && c < budget) begin
      @(negedge clk); #1; c++;
    end
    chk("words_reached", acc_cnt[i] >= n, 1);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    int rr_order[6];
    rr_order = '{0, 1, 3, 0, 1, 3};
    bus.req = '0;
    bus.req_valid = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_core_reset", bus.core_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_flag", bus.core_data_in_flag, 0);
    chk("rst_data", bus.core_data_in, 0);
    chk("rst_ready", bus.req_ready, 0);
    reset = 1'b0;

    // Single job on requester 1, calc_done 50 cycles into compute.
    do_reset();
    calc_delay = 50;
    bus.req_valid = 4'b0010;
    bus.req = 4'b0010;
    wait_end(1, 2000);
    bus.req = '0;
    @(negedge clk); #1;
    chk("single_busy_fell", busy, 0);
    chk("single_grant_id", grant_id, 1);
    chk("single_done", done_cnt[1], 1);
    chk("single_err", err_cnt[1], 0);
    chk("single_flag_pulses", flag_cnt, 1);
    chk("single_core_rst_cycles", rstbusy_cnt, 2);
    chk("single_words", acc_cnt[1], 651);

    // Round robin among requesters 0, 1, 3.
    do_reset();
    calc_delay = 10;
    bus.req_valid = 4'b1111;
    bus.req = 4'b1011;
    n = 0;
    while (done_cnt[0] + done_cnt[1] + done_cnt[3] < 6 && n < 6000) begin
      @(negedge clk); #1; n++;
    end
    bus.req = '0;
    chk("rr_jobs", grant_q.size(), 6);
    for (int i = 0; i < 6; i++) if (i < grant_q.size()) chk("rr_order", grant_q[i], rr_order[i]);
    chk("rr_done0", done_cnt[0], 2);
    chk("rr_done1", done_cnt[1], 2);
    chk("rr_done3", done_cnt[3], 2);
    chk("rr_errs", err_cnt[0] + err_cnt[1] + err_cnt[3], 0);

    // Requester 2 drops valid at word 100.
    do_reset();
    calc_delay = -1;
    bus.req_valid = 4'b0100;
    bus.req = 4'b0100;
    wait_acc(2, 99, 200);
    bus.req_valid = 4'b0000;
    wait_end(2, 50);
    bus.req = '0;
    chk("stall_err", err_cnt[2], 1);
    chk("stall_done", done_cnt[2], 0);
    chk("stall_words", acc_cnt[2], 99);
    @(negedge clk); #1;
    chk("stall_idle_core_reset", bus.core_reset, 1);

    // Timeout on requester 0, then rr advance and abort by req drop.
    do_reset();
    calc_delay = -1;
    bus.req_valid = 4'b0011;
    bus.req = 4'b0001;
    wait_acc(0, 651, 800);
    n = 0;
    while (err_cnt[0] == 0 && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("timeout_cycles", n, 64);
    chk("timeout_done", done_cnt[0], 0);
    bus.req = 4'b0011;
    n = 0;
    while (grant_q.size() < 2 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("timeout_next_jobs", grant_q.size(), 2);
    if (grant_q.size() >= 2) chk("timeout_rr_advanced", grant_q[1], 1);
    bus.req = '0;
    wait_end(1, 20);
    chk("abort_err", err_cnt[1], 1);

    // calc_done in the cycle the timeout would fire.
    do_reset();
    calc_delay = 63;
    bus.req_valid = 4'b0001;
    bus.req = 4'b0001;
    wait_end(0, 2000);
    bus.req = '0;
    chk("simul_done", done_cnt[0], 1);
    chk("simul_err", err_cnt[0], 0);

    // Async reset in the middle of requester 3 streaming.
    do_reset();
    calc_delay = 5;
    bus.req_valid = 4'b1111;
    bus.req = 4'b0010;
    wait_end(1, 2000);
    bus.req = 4'b1010;
    wait_acc(3, 300, 400);
    #2 reset = 1'b1;
    #1;
    chk("areset_core_reset", bus.core_reset, 1);
    chk("areset_flag", bus.core_data_in_flag, 0);
    chk("areset_data", bus.core_data_in, 0);
    chk("areset_ready", bus.req_ready, 0);
    chk("areset_done", bus.req_done, 0);
    chk("areset_err", bus.req_err, 0);
    chk("areset_busy", busy, 0);
    chk("areset_grant_id", grant_id, 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    while (grant_q.size() < 1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("areset_restart", grant_q.size(), 1);
    if (grant_q.size() >= 1) chk("areset_rr_zero", grant_q[0], 1);
    chk("areset_no_pulse3", done_cnt[3] + err_cnt[3], 0);
    wait_end(1, 2000);
    bus.req = '0;
    chk("areset_job_done", done_cnt[1], 1);
    @(negedge clk); #1;
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    checks++;
    $display("FAIL watchdog: got still running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
